// File: rtl/coreboard1588_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | coreboard1588_pkg: AXI response codes and bridge FSM state types   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package coreboard1588_pkg;

  localparam logic [1:0]  c_resp_okay   = 2'b00;
  localparam logic [1:0]  c_resp_slverr = 2'b10;
  localparam logic [31:0] c_rd_err_data = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_WAIT = 2'd2,
    W_RESP = 2'd3
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_WAIT = 2'd2,
    R_RESP = 2'd3
  } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/coreboard1588_up_timeout.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | coreboard1588_up_timeout: saturating ack-wait counter              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module coreboard1588_up_timeout #(
  parameter int C_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int                c_cw   = $clog2(C_TIMEOUT + 1);
  localparam logic [c_cw-1:0]   c_last = c_cw'(C_TIMEOUT - 1);

  logic [c_cw-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != c_last)) begin
      r_count <= r_count + c_cw'(1);
    end
  end

  // High during the last permitted wait cycle; an ack in that cycle still wins.
  assign o_expired = i_enable && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/coreboard1588_axi_up_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | coreboard1588_axi_up_bridge: AXI4-Lite slave to up_* register bus  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module coreboard1588_axi_up_bridge
  import coreboard1588_pkg::*;
#(
  parameter int C_ADDR_WIDTH = 10,
  parameter int C_DATA_WIDTH = 32,
  parameter int C_TIMEOUT    = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [C_ADDR_WIDTH+1:0]   s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [C_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [C_ADDR_WIDTH+1:0]   s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [C_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [C_ADDR_WIDTH-1:0]   up_wr_addr,
  output logic                      up_wr_req,
  output logic [C_DATA_WIDTH-1:0]   up_wr_din,
  input  logic                      up_wr_ack,
  output logic [C_ADDR_WIDTH-1:0]   up_rd_addr,
  output logic                      up_rd_req,
  input  logic [C_DATA_WIDTH-1:0]   up_rd_dout,
  input  logic                      up_rd_ack
);

  wr_state_t r_wstate, w_wstate_nxt;
  rd_state_t r_rstate, w_rstate_nxt;

  logic                      r_rdy_en;
  logic                      r_aw_got, r_w_got;
  logic [C_DATA_WIDTH/8-1:0] r_wstrb;
  logic                      w_aw_hs, w_w_hs, w_ar_hs, w_wstrb_full;
  logic                      w_wr_expired, w_rd_expired;
  logic                      w_unused_addr_lsbs;

  assign w_aw_hs      = s_axi_awvalid & s_axi_awready;
  assign w_w_hs       = s_axi_wvalid  & s_axi_wready;
  assign w_ar_hs      = s_axi_arvalid & s_axi_arready;
  assign w_wstrb_full = (r_wstrb == '1);
  assign w_unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // Keeps every ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rdy_en <= 1'b0;
    else        r_rdy_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE: if ((r_aw_got | w_aw_hs) & (r_w_got | w_w_hs)) w_wstate_nxt = W_REQ;
      W_REQ:  w_wstate_nxt = w_wstrb_full ? W_WAIT : W_RESP;
      W_WAIT: if (up_wr_ack | w_wr_expired) w_wstate_nxt = W_RESP;
      W_RESP: if (s_axi_bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE: if (w_ar_hs) w_rstate_nxt = R_REQ;
      R_REQ:  w_rstate_nxt = R_WAIT;
      R_WAIT: if (up_rd_ack | w_rd_expired) w_rstate_nxt = R_RESP;
      R_RESP: if (s_axi_rready) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    up_wr_req     = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_arready = 1'b0;
    up_rd_req     = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        s_axi_awready = r_rdy_en & ~r_aw_got;
        s_axi_wready  = r_rdy_en & ~r_w_got;
      end
      W_REQ:   up_wr_req    = w_wstrb_full;
      W_RESP:  s_axi_bvalid = 1'b1;
      default: ;
    endcase
    case (r_rstate)
      R_IDLE:  s_axi_arready = r_rdy_en;
      R_REQ:   up_rd_req     = 1'b1;
      R_RESP:  s_axi_rvalid  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aw_got    <= 1'b0;
      r_w_got     <= 1'b0;
      up_wr_addr  <= '0;
      up_wr_din   <= '0;
      r_wstrb     <= '0;
      s_axi_bresp <= c_resp_okay;
    end else begin
      if (w_aw_hs) begin
        r_aw_got   <= 1'b1;
        up_wr_addr <= s_axi_awaddr[C_ADDR_WIDTH+1:2];
      end else if (r_wstate == W_REQ) begin
        r_aw_got   <= 1'b0;
      end
      if (w_w_hs) begin
        r_w_got   <= 1'b1;
        up_wr_din <= s_axi_wdata;
        r_wstrb   <= s_axi_wstrb;
      end else if (r_wstate == W_REQ) begin
        r_w_got   <= 1'b0;
      end
      if ((r_wstate == W_REQ) && !w_wstrb_full)            s_axi_bresp <= c_resp_slverr;
      else if ((r_wstate == W_WAIT) && up_wr_ack)          s_axi_bresp <= c_resp_okay;
      else if ((r_wstate == W_WAIT) && w_wr_expired)       s_axi_bresp <= c_resp_slverr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_rd_addr  <= '0;
      s_axi_rdata <= '0;
      s_axi_rresp <= c_resp_okay;
    end else begin
      if (w_ar_hs) up_rd_addr <= s_axi_araddr[C_ADDR_WIDTH+1:2];
      if ((r_rstate == R_WAIT) && up_rd_ack) begin
        s_axi_rdata <= up_rd_dout;
        s_axi_rresp <= c_resp_okay;
      end else if ((r_rstate == R_WAIT) && w_rd_expired) begin
        s_axi_rdata <= c_rd_err_data;
        s_axi_rresp <= c_resp_slverr;
      end
    end
  end

  coreboard1588_up_timeout #(.C_TIMEOUT(C_TIMEOUT)) u_wr_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (r_wstate == W_REQ),
    .i_enable  (r_wstate == W_WAIT),
    .o_expired (w_wr_expired)
  );

  coreboard1588_up_timeout #(.C_TIMEOUT(C_TIMEOUT)) u_rd_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (r_rstate == R_REQ),
    .i_enable  (r_rstate == R_WAIT),
    .o_expired (w_rd_expired)
  );

endmodule
`default_nettype wire

// File: tb/tb_coreboard1588_axi_up_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_coreboard1588_axi_up_bridge: directed bench with cycle model    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_coreboard1588_axi_up_bridge;

  localparam int         TO     = 15;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [11:0] s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic [9:0]  up_wr_addr;
  logic        up_wr_req;
  logic [31:0] up_wr_din;
  logic        up_wr_ack = 1'b0;
  logic [9:0]  up_rd_addr;
  logic        up_rd_req;
  logic [31:0] up_rd_dout = '0;
  logic        up_rd_ack = 1'b0;

  coreboard1588_axi_up_bridge #(
    .C_ADDR_WIDTH(10), .C_DATA_WIDTH(32), .C_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .up_wr_addr(up_wr_addr), .up_wr_req(up_wr_req), .up_wr_din(up_wr_din), .up_wr_ack(up_wr_ack),
    .up_rd_addr(up_rd_addr), .up_rd_req(up_rd_req), .up_rd_dout(up_rd_dout), .up_rd_ack(up_rd_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  // Expected transaction timeline, in cycle numbers; -1 means nothing pending.
  int          m_aw_hs = -1, m_w_hs = -1, m_wreq = -1, m_bf = -1, m_bu = -1;
  int          m_ar_hs = -1, m_rreq = -1, m_rf = -1, m_ru = -1;
  logic [9:0]  m_waddr = '0, m_raddr = '0;
  logic [31:0] m_wdin = '0, m_rdata = '0;
  logic [1:0]  m_bresp = '0, m_rresp = '0;

  int          n_wreq = 0, n_rreq = 0;
  logic [1:0]  last_bresp = 2'b11, last_rresp = 2'b11;
  logic [31:0] last_rdata = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic clear_model();
    m_aw_hs = -1; m_w_hs = -1; m_wreq = -1; m_bf = -1; m_bu = -1;
    m_ar_hs = -1; m_rreq = -1; m_rf = -1; m_ru = -1;
  endtask

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      chk("awready", s_axi_awready, !(cyc > m_aw_hs && cyc <= m_bu));
      chk("wready",  s_axi_wready,  !(cyc > m_w_hs  && cyc <= m_bu));
      chk("up_wr_req", up_wr_req, cyc == m_wreq);
      if (up_wr_req) begin
        n_wreq++;
        chk("up_wr_addr", up_wr_addr, m_waddr);
        chk("up_wr_din",  up_wr_din,  m_wdin);
      end
      chk("bvalid", s_axi_bvalid, cyc >= m_bf && cyc <= m_bu);
      if (s_axi_bvalid) begin
        chk("bresp", s_axi_bresp, m_bresp);
        last_bresp = s_axi_bresp;
      end
      chk("arready", s_axi_arready, !(cyc > m_ar_hs && cyc <= m_ru));
      chk("up_rd_req", up_rd_req, cyc == m_rreq);
      if (up_rd_req) begin
        n_rreq++;
        chk("up_rd_addr", up_rd_addr, m_raddr);
      end
      chk("rvalid", s_axi_rvalid, cyc >= m_rf && cyc <= m_ru);
      if (s_axi_rvalid) begin
        chk("rdata", s_axi_rdata, m_rdata);
        chk("rresp", s_axi_rresp, m_rresp);
        last_rdata = s_axi_rdata;
        last_rresp = s_axi_rresp;
      end
    end
  end

  // ack_k: ack driven in the k-th cycle after the req cycle (<0 = never).
  task automatic wr_txn(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                        input int aw_off, input int w_off, input int ack_k, input int rdy_dly);
    int s, l, ack_c;
    @(negedge clk);
    s = cyc + 1;
    l = s + ((aw_off > w_off) ? aw_off : w_off);
    ack_c = (strb == 4'hF && ack_k >= 0) ? l + 2 + ack_k : -1;
    m_waddr = addr[11:2];
    m_wdin  = data;
    m_aw_hs = s + aw_off;
    m_w_hs  = s + w_off;
    if (strb != 4'hF) begin
      m_wreq = -1; m_bf = l + 2; m_bresp = SLVERR;
    end else if (ack_k >= 0 && ack_k < TO) begin
      m_wreq = l + 1; m_bf = ack_c + 1; m_bresp = OKAY;
    end else begin
      m_wreq = l + 1; m_bf = l + 2 + TO; m_bresp = SLVERR;
    end
    m_bu = m_bf + rdy_dly;
    s_axi_awaddr = addr;
    s_axi_wdata  = data;
    s_axi_wstrb  = strb;
    for (int c = s; c <= m_bu; c++) begin
      @(negedge clk);
      s_axi_awvalid = (c == m_aw_hs);
      s_axi_wvalid  = (c == m_w_hs);
      up_wr_ack     = (c == ack_c);
      s_axi_bready  = (c == m_bu);
    end
    @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; up_wr_ack = 1'b0; s_axi_bready = 1'b0;
  endtask

  task automatic rd_txn(input logic [11:0] addr, input logic [31:0] data,
                        input int ack_k, input int rdy_dly);
    int s, ack_c;
    @(negedge clk);
    s = cyc + 1;
    ack_c   = (ack_k >= 0) ? s + 2 + ack_k : -1;
    m_raddr = addr[11:2];
    m_ar_hs = s;
    m_rreq  = s + 1;
    if (ack_k >= 0 && ack_k < TO) begin
      m_rf = ack_c + 1; m_rdata = data; m_rresp = OKAY;
    end else begin
      m_rf = s + 2 + TO; m_rdata = 32'hDEADBEEF; m_rresp = SLVERR;
    end
    m_ru = m_rf + rdy_dly;
    s_axi_araddr = addr;
    for (int c = s; c <= m_ru; c++) begin
      @(negedge clk);
      s_axi_arvalid = (c == m_ar_hs);
      up_rd_ack     = (c == ack_c);
      up_rd_dout    = (c == ack_c) ? data : ~data;
      s_axi_rready  = (c == m_ru);
    end
    @(negedge clk);
    s_axi_arvalid = 1'b0; up_rd_ack = 1'b0; s_axi_rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    int s;
    #2;
    chk("rst_awready", s_axi_awready, 1'b0);
    chk("rst_wready",  s_axi_wready,  1'b0);
    chk("rst_arready", s_axi_arready, 1'b0);
    chk("rst_bvalid",  s_axi_bvalid,  1'b0);
    chk("rst_rvalid",  s_axi_rvalid,  1'b0);
    chk("rst_rdata",   s_axi_rdata,   32'h0);
    chk("rst_up_wr_addr", up_wr_addr, 10'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_awready", s_axi_awready, 1'b0);
    chk("rel_arready", s_axi_arready, 1'b0);
    @(posedge clk); #1;
    mon_en = 1'b1;

    snap = n_wreq;
    wr_txn(12'h020, 32'h12345678, 4'hF, 0, 2, 0, 0);
    chk("pin_wr_addr", up_wr_addr, 10'd8);
    chk("pin_wr_din",  up_wr_din,  32'h12345678);
    chk("pin_bresp_ok", last_bresp, 2'b00);
    chk("pin_wreq_once", n_wreq - snap, 1);

    wr_txn(12'h104, 32'hA5A50F0F, 4'hF, 2, 0, 3, 1);
    last_bresp = 2'b11;
    wr_txn(12'hFFC, 32'hCAFEF00D, 4'hF, 0, 0, 14, 0);
    chk("pin_bresp_ack14", last_bresp, 2'b00);
    wr_txn(12'h008, 32'h0000AAAA, 4'hF, 0, 0, 15, 2);
    chk("pin_bresp_timeout", last_bresp, 2'b10);

    snap = n_wreq;
    wr_txn(12'h010, 32'h11112222, 4'h3, 1, 0, 0, 0);
    chk("pin_strb_no_req", n_wreq - snap, 0);
    chk("pin_bresp_strb", last_bresp, 2'b10);

    rd_txn(12'h004, 32'h00010002, 0, 0);
    chk("pin_rd_addr",  up_rd_addr, 10'd1);
    chk("pin_rdata_ok", last_rdata, 32'h00010002);
    chk("pin_rresp_ok", last_rresp, 2'b00);
    rd_txn(12'h3FC, 32'h55555555, -1, 1);
    chk("pin_rd_addr_3fc", up_rd_addr, 10'h0FF);
    chk("pin_rdata_to", last_rdata, 32'hDEADBEEF);
    chk("pin_rresp_to", last_rresp, 2'b10);
    rd_txn(12'h800, 32'h89ABCDEF, 14, 0);
    chk("pin_rdata_ack14", last_rdata, 32'h89ABCDEF);

    fork
      wr_txn(12'h030, 32'h0BADF00D, 4'hF, 0, 0, 1, 5);
      rd_txn(12'h034, 32'h13572468, 2, 5);
    join
    chk("pin_conc_bresp", last_bresp, 2'b00);
    chk("pin_conc_rdata", last_rdata, 32'h13572468);

    // Reset while the write sits in W_WAIT with no ack coming.
    @(negedge clk);
    s = cyc + 1;
    m_waddr = 10'h050; m_wdin = 32'h77778888;
    m_aw_hs = s; m_w_hs = s; m_wreq = s + 1; m_bf = s + 2 + TO; m_bu = s + 1000;
    m_bresp = SLVERR;
    @(negedge clk);
    s_axi_awaddr = 12'h140; s_axi_wdata = 32'h77778888; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    repeat (4) @(negedge clk);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_bvalid",  s_axi_bvalid,  1'b0);
    chk("midrst_awready", s_axi_awready, 1'b0);
    chk("midrst_up_wr_addr", up_wr_addr, 10'h0);
    chk("midrst_up_wr_din",  up_wr_din,  32'h0);
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrel_awready", s_axi_awready, 1'b0);
    @(posedge clk); #1;
    mon_en = 1'b1;
    repeat (20) @(negedge clk);

    last_bresp = 2'b11;
    wr_txn(12'h040, 32'hFEEDFACE, 4'hF, 1, 1, 0, 0);
    chk("pin_post_rst_bresp", last_bresp, 2'b00);
    chk("pin_post_rst_din",   up_wr_din,  32'hFEEDFACE);

    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
